aes_decrypt: RTL and testbench

//  Iterative AES-128 decryption core, the inverse of the aes encryption core. Takes a
//  128-bit cipher block and key and returns the plaintext, one round per clock.

---
 rtl/aes_decrypt.sv | 235 +++++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core: forward key expansion to K10 (skipped on a
// key-cache hit), then ten inverse rounds walking the key schedule backwards.
// Byte k of a 128-bit block sits at bits [127-8k -: 8]; state is column-major.
module aes_decrypt #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         we,
    input  logic [127:0] cipher,
    input  logic [127:0] secret,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {S_IDLE, S_KEY, S_DEC} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;      // holds the latched cipher during KEY
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] secret_q, secret_d;
    logic [127:0] ckey_q, ckey_d;      // key of the cached schedule
    logic [127:0] ck10_q, ck10_d;      // cached last round key
    logic         cvld_q, cvld_d;
    logic [127:0] pt_q, pt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ rcon in the top byte.
    function automatic logic [31:0] key_mix(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ key_mix(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ key_mix(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows followed by InvSubBytes.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [127:0] k_fwd, k_inv, dec_round, dec_next;
    logic         cache_hit;

    // Round datapath: one forward key step, one inverse key step and one inverse round.
    always_comb begin
        k_fwd     = key_fwd(rkey_q, rcon(cnt_q + 4'd1));
        k_inv     = key_inv(rkey_q, rcon(4'd10 - cnt_q));
        dec_round = inv_shift_sub(data_q) ^ k_inv;
        dec_next  = (cnt_q == 4'd9) ? dec_round : inv_mix(dec_round);
        cache_hit = KEY_CACHE && cvld_q && (secret == ckey_q);
    end

    // Next-state and register-update logic for IDLE -> KEY -> DEC -> IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rkey_d   = rkey_q;
        secret_d = secret_q;
        ckey_d   = ckey_q;
        ck10_d   = ck10_q;
        cvld_d   = cvld_q;
        pt_d     = pt_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (we) begin
                    cnt_d    = 4'd0;
                    secret_d = secret;
                    if (cache_hit) begin
                        data_d  = cipher ^ ck10_q;
                        rkey_d  = ck10_q;
                        state_d = S_DEC;
                    end else begin
                        data_d  = cipher;
                        rkey_d  = secret;
                        state_d = S_KEY;
                    end
                end
            end
            S_KEY: begin
                rkey_d = k_fwd;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    data_d  = data_q ^ k_fwd;
                    ck10_d  = k_fwd;
                    ckey_d  = secret_q;
                    cvld_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                data_d = dec_next;
                rkey_d = k_inv;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    pt_d    = dec_next;
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset also invalidates the key cache.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            data_q   <= '0;
            rkey_q   <= '0;
            secret_q <= '0;
            ckey_q   <= '0;
            ck10_q   <= '0;
            cvld_q   <= 1'b0;
            pt_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rkey_q   <= rkey_d;
            secret_q <= secret_d;
            ckey_q   <= ckey_d;
            ck10_q   <= ck10_d;
            cvld_q   <= cvld_d;
            pt_q     <= pt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign plaintext = pt_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: a forward AES-128 reference encrypts random blocks, the
// expected plaintexts go into a queue, and each completion is popped and compared.
module tb_aes_decrypt;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         we_c, we_n;
    logic [127:0] cipher_c, cipher_n, secret_c, secret_n;
    logic [127:0] pt_c, pt_n;
    logic         busy_c, busy_n, done_c, done_n;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];
    logic [127:0] tb_ck_key;
    logic         tb_ck_vld = 1'b0;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic [2047:0] sbox_vec = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    always #5 clock = ~clock;

    aes_decrypt #(.KEY_CACHE(1'b1)) dut_c (
        .clock(clock), .reset_n(reset_n), .we(we_c), .cipher(cipher_c), .secret(secret_c),
        .plaintext(pt_c), .busy(busy_c), .done(done_c));

    aes_decrypt #(.KEY_CACHE(1'b0)) dut_n (
        .clock(clock), .reset_n(reset_n), .we(we_n), .cipher(cipher_n), .secret(secret_n),
        .plaintext(pt_n), .busy(busy_n), .done(done_n));

    function automatic logic [7:0] tb_sb(input logic [7:0] x);
        return sbox_vec[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] tb_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {tb_sb(k[23:16]) ^ rc, tb_sb(k[15:8]), tb_sb(k[7:0]), tb_sb(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st[16];
        logic [7:0]   tmp[16];
        logic [7:0]   a0, a1, a2, a3, rc;
        logic [127:0] rk, o;
        rk = key;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            rk = tb_expand(rk, rc);
            rc = x2(rc);
            for (int i = 0; i < 16; i++) tmp[i] = tb_sb(st[i]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) st[4*c+w] = tmp[4*((c+w)%4)+w];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
                    st[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_c : busy_n;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_c : done_n;
    endfunction

    function automatic logic [127:0] pt_of(input int sel);
        return (sel == 0) ? pt_c : pt_n;
    endfunction

    // One operation: drive for one edge, scramble inputs, wait (bounded) for done.
    task automatic run_op(input int sel, input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] pt, output int lat, output int bcnt,
                          output logic [127:0] got, output logic [127:0] exp);
        @(negedge clock);
        if (sel == 0) begin we_c = 1'b1; cipher_c = ct; secret_c = key; end
        else          begin we_n = 1'b1; cipher_n = ct; secret_n = key; end
        exp_q.push_back(pt);
        @(posedge clock);
        #1;
        if (sel == 0) begin we_c = 1'b0; cipher_c = rnd128(); secret_c = rnd128(); end
        else          begin we_n = 1'b0; cipher_n = rnd128(); secret_n = rnd128(); end
        lat  = 0;
        bcnt = busy_of(sel) ? 1 : 0;
        while (lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy_of(sel)) bcnt++;
            if (done_of(sel)) break;
        end
        got = pt_of(sel);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~pt;
        if (sel == 0) begin tb_ck_key = key; tb_ck_vld = 1'b1; end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        we_c = 1'b0; we_n = 1'b0;
        cipher_c = '0; cipher_n = '0; secret_c = '0; secret_n = '0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (pt_c !== '0) begin n_fail++; $display("FAIL reset_pt got=%h exp=0", pt_c); end
        n_checks++; if ({busy_c, done_c, busy_n, done_n} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy_c, done_c, busy_n, done_n}); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_fips();
        int lat, bcnt;
        logic [127:0] got, exp;
        run_op(0, FIPS_CT, FIPS_KEY, FIPS_PT, lat, bcnt, got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fips_pt got=%h exp=%h", got, exp); end
        n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL fips_latency got=%0d exp=20", lat); end
        n_checks++; if (bcnt !== 20) begin n_fail++; $display("FAIL fips_busy got=%0d exp=20", bcnt); end
        @(posedge clock);
        #1;
        n_checks++; if (done_c !== 1'b0) begin n_fail++; $display("FAIL done_pulse got=%b exp=0", done_c); end
        n_checks++; if (pt_c !== FIPS_PT) begin n_fail++; $display("FAIL pt_hold got=%h exp=%h", pt_c, FIPS_PT); end
        run_op(0, FIPS_CT, FIPS_KEY, FIPS_PT, lat, bcnt, got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL hit_pt got=%h exp=%h", got, exp); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL hit_latency got=%0d exp=10", lat); end
        n_checks++; if (bcnt !== 10) begin n_fail++; $display("FAIL hit_busy got=%0d exp=10", bcnt); end
        for (int k = 0; k < 2; k++) begin
            run_op(1, FIPS_CT, FIPS_KEY, FIPS_PT, lat, bcnt, got, exp);
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL nocache_pt[%0d] got=%h exp=%h", k, got, exp); end
            n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL nocache_latency[%0d] got=%0d exp=20", k, lat); end
        end
    endtask

    task automatic test_random();
        int lat, bcnt, exp_lat;
        logic [127:0] key, pt, got, exp;
        for (int i = 0; i < 1000; i++) begin
            key = ($urandom_range(0, 3) == 0) ? tb_ck_key : rnd128();
            pt  = rnd128();
            exp_lat = (tb_ck_vld && key == tb_ck_key) ? 10 : 20;
            run_op(0, aes_enc(pt, key), key, pt, lat, bcnt, got, exp);
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rand_pt[%0d] got=%h exp=%h", i, got, exp); end
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
            n_checks++; if (bcnt !== exp_lat) begin n_fail++; $display("FAIL rand_busy[%0d] got=%0d exp=%0d", i, bcnt, exp_lat); end
        end
    endtask

    // we held for 40 edges on the no-cache core: accepts on edge 0 and edge 21.
    task automatic test_we_held();
        logic [127:0] key, got, exp;
        logic [127:0] pts[40];
        logic [127:0] cts[40];
        int pulses, first_edge, second_edge;
        key = rnd128();
        for (int i = 0; i < 40; i++) begin pts[i] = rnd128(); cts[i] = aes_enc(pts[i], key); end
        exp_q.push_back(pts[0]);
        exp_q.push_back(pts[21]);
        pulses = 0; first_edge = -1; second_edge = -1;
        for (int e = 0; e < 80; e++) begin
            @(negedge clock);
            if (e < 40) begin we_n = 1'b1; cipher_n = cts[e]; secret_n = key; end
            else        begin we_n = 1'b0; cipher_n = rnd128(); end
            @(posedge clock);
            #1;
            if (done_n) begin
                pulses++;
                if (pulses == 1) first_edge = e; else if (pulses == 2) second_edge = e;
                got = pt_n;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
                n_checks++; if (got !== exp) begin n_fail++; $display("FAIL held_pt[%0d] got=%h exp=%h", pulses, got, exp); end
            end
        end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL held_pulses got=%0d exp=2", pulses); end
        n_checks++; if (first_edge !== 20 || second_edge !== 41) begin
            n_fail++; $display("FAIL held_edges got=%0d,%0d exp=20,41", first_edge, second_edge); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, seen;
        logic [127:0] key, pt, got, exp;
        key = rnd128();
        pt  = rnd128();
        @(negedge clock);
        we_c = 1'b1; cipher_c = aes_enc(pt, key); secret_c = key;
        exp_q.push_back(pt);
        @(posedge clock);
        #1;
        we_c = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        tb_ck_vld = 1'b0;
        n_checks++; if ({busy_c, done_c} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags got=%b exp=00", {busy_c, done_c}); end
        n_checks++; if (pt_c !== '0) begin n_fail++; $display("FAIL midreset_pt got=%h exp=0", pt_c); end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clock); #1; if (done_c || busy_c) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL lost_op_activity got=%0d exp=0", seen); end
        run_op(0, aes_enc(pt, key), key, pt, lat, bcnt, got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL after_reset_pt got=%h exp=%h", got, exp); end
        n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL after_reset_latency got=%0d exp=20", lat); end
    endtask

    task automatic test_key_change();
        int lat, bcnt;
        logic [127:0] k1, k2, pt, got, exp;
        k1 = rnd128();
        k2 = k1 ^ 128'h1;
        pt = rnd128();
        run_op(0, aes_enc(pt, k1), k1, pt, lat, bcnt, got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL k1_pt got=%h exp=%h", got, exp); end
        n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL k1_latency got=%0d exp=20", lat); end
        pt = rnd128();
        run_op(0, aes_enc(pt, k2), k2, pt, lat, bcnt, got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL k2_pt got=%h exp=%h", got, exp); end
        n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL k2_latency got=%0d exp=20", lat); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_random();
        test_we_held();
        test_reset_mid();
        test_key_change();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
